// File: rtl/uart_pkg.sv
// uart_pkg: shared read-FSM encoding and default word width for the UART transmit path
package uart_pkg;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, LOAD, VALID} rd_state_e;
endpackage

// File: rtl/launch_fifo_mem.sv
// launch_fifo_mem: simple dual-port RAM, one write port and one registered read port, array not reset
module launch_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data_q <= mem[rd_addr];
  end
  assign rd_data = rd_data_q;
endmodule

// File: rtl/launch_fifo.sv
// launch_fifo: transmit queue with count-based flags, sticky overflow, flush and a valid/ack output register
module launch_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = 8,
  parameter int AFULL_LVL = 2**ADDR_W-4
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic              overflow,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] data_out,
  output logic              tx_valid,
  input  logic              tx_ack
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW = ADDR_W+1;
  rd_state_e state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic full_q, full_d, afull_q, afull_d, empty_q, empty_d, ovf_q, ovf_d;
  logic valid_q, valid_d;
  logic [DATA_W-1:0] dout_q, dout_d, rd_data;
  logic clr, wr_acc, pop, avail, rd_en;
  launch_fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk(CLK100MHZ), .we(wr_acc), .wr_addr(wr_ptr_q), .wr_data(data_in),
    .re(rd_en), .rd_addr(rd_ptr_q), .rd_data(rd_data)
  );
  // count includes the word in flight or held at the output, so RAM holds count-1 unread words outside IDLE
  always_comb begin
    clr = reset | flush;
    wr_acc = wr_en & ~full_q & ~clr;
    pop = tx_ack & valid_q;
    avail = (state_q == IDLE) ? (count_q != '0) : (count_q > CW'(1));
    rd_en = avail & ((state_q == IDLE) | ((state_q == VALID) & pop));
    state_d = (state_q == LOAD) ? VALID : rd_en ? LOAD : ((state_q == VALID) & ~pop) ? VALID : IDLE;
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + ADDR_W'(rd_en);
    count_d = count_q + CW'(wr_acc) - CW'(pop);
    full_d = count_d == CW'(DEPTH);
    afull_d = count_d >= CW'(AFULL_LVL);
    empty_d = count_d == '0;
    ovf_d = ovf_q | (wr_en & full_q);
    dout_d = (state_q == LOAD) ? rd_data : dout_q;
    valid_d = state_d == VALID;
  end
  always_ff @(posedge CLK100MHZ) begin
    if (clr) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      afull_q <= 1'b0;
      empty_q <= 1'b1;
      ovf_q <= 1'b0;
      dout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      full_q <= full_d;
      afull_q <= afull_d;
      empty_q <= empty_d;
      ovf_q <= ovf_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
    end
  end
  assign full = full_q;
  assign almost_full = afull_q;
  assign empty = empty_q;
  assign overflow = ovf_q;
  assign count = count_q;
  assign data_out = dout_q;
  assign tx_valid = valid_q;
endmodule

// File: tb/tb_launch_fifo.sv
// tb_launch_fifo: directed scoreboard bench for an 8-deep launch_fifo
module tb_launch_fifo;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, wr_en = 1'b0, tx_ack = 1'b0;
  logic [7:0] data_in = '0;
  logic full, almost_full, empty, overflow, tx_valid;
  logic [3:0] count;
  logic [7:0] data_out;
  int checks = 0, errors = 0;
  logic [7:0] sb [$];

  launch_fifo #(.DATA_W(8), .ADDR_W(3), .AFULL_LVL(4)) dut (
    .CLK100MHZ(clk), .reset(reset), .flush(flush), .data_in(data_in), .wr_en(wr_en),
    .full(full), .almost_full(almost_full), .empty(empty), .overflow(overflow),
    .count(count), .data_out(data_out), .tx_valid(tx_valid), .tx_ack(tx_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input bit push);
    data_in = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    if (push) sb.push_back(d);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 10 && !tx_valid; i++) tick();
    chk("valid_wait", tx_valid, 1);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] exp;
    wait_valid();
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    chk(tag, data_out, exp);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_valid"}, tx_valid, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, almost_full, 0);
  endtask

  initial begin
    tick();
    do_reset();
    chk_idle("rst");
    chk("rst_ovf", overflow, 0);
    chk("rst_dout", data_out, 0);

    // single word latency: write at edge N, valid after N+2
    wr(8'hA5, 1'b1);
    chk("lat_n0", tx_valid, 0);
    tick();
    chk("lat_n1", tx_valid, 0);
    tick();
    chk("lat_n2", tx_valid, 1);
    chk("lat_data", data_out, 8'hA5);
    chk("lat_count", count, 1);
    chk("lat_empty", empty, 0);
    void'(sb.pop_front());
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk_idle("lat_ack");

    // fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      wr(8'h10 + 8'(i), 1'b1);
      chk("fill_count", count, i + 1);
      chk("fill_afull", almost_full, (i + 1) >= 4);
      chk("fill_full", full, (i + 1) == 8);
    end
    wr(8'hFF, 1'b0);
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 8; i++) pop_chk("drain_data");
    chk_idle("drain");
    chk("drain_ovf_sticky", overflow, 1);

    // wrap-around
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr(8'h40 + 8'(i), 1'b1);
      chk("wrap_le8", count <= 4'd8, 1);
      pop_chk("wrap_data");
    end
    chk_idle("wrap");

    // full queue with simultaneous write and ack: write must be rejected
    for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i), 1'b1);
    wait_valid();
    chk("fa_data", data_out, sb.pop_front());
    data_in = 8'hEE;
    wr_en = 1'b1;
    tx_ack = 1'b1;
    tick();
    wr_en = 1'b0;
    tx_ack = 1'b0;
    chk("fa_count", count, 7);
    chk("fa_ovf", overflow, 1);
    chk("fa_full", full, 0);
    for (int i = 0; i < 7; i++) pop_chk("fa_drain");
    chk_idle("fa");

    // flush with write in the same cycle clears everything including overflow
    for (int i = 0; i < 5; i++) wr(8'h20 + 8'(i), 1'b1);
    wait_valid();
    flush = 1'b1;
    wr_en = 1'b1;
    data_in = 8'h99;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    sb.delete();
    chk_idle("flush");
    chk("flush_ovf", overflow, 0);
    wr(8'h3C, 1'b1);
    pop_chk("flush_first");
    chk_idle("flush_after");

    // half-full with simultaneous write and ack: count unchanged
    for (int i = 0; i < 4; i++) wr(8'h60 + 8'(i), 1'b1);
    wait_valid();
    chk("hf_data", data_out, sb.pop_front());
    data_in = 8'h44;
    wr_en = 1'b1;
    tx_ack = 1'b1;
    tick();
    wr_en = 1'b0;
    tx_ack = 1'b0;
    sb.push_back(8'h44);
    chk("hf_count", count, 4);
    for (int i = 0; i < 4; i++) pop_chk("hf_drain");
    chk_idle("hf");

    // ack while empty is ignored
    tx_ack = 1'b1;
    tick();
    tick();
    tx_ack = 1'b0;
    chk_idle("ack_empty");
    chk("ack_empty_ovf", overflow, 0);

    // reset while the FSM is in LOAD discards the word
    wr(8'h5A, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("rst_load");
    chk("rst_load_dout", data_out, 0);
    tick();
    tick();
    chk("rst_load_valid_later", tx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/launch_fifo.md
Name: launch_fifo

Overview:
Parametrised transmit-queue buffer between the host write side and UART_launcher, clocked only on CLK100MHZ.
- Circular buffer with read/write pointers, full/empty/almost-full flags, occupancy count, sticky overflow flag, and flush.
- Registered output stage with a valid/ack handshake, so the launcher pops one word per frame rather than being driven by a baud-clock read.

Parameters:
DATA_W, 8, width of each queued word (bits)
ADDR_W, 8, pointer width; DEPTH = 2**ADDR_W words of capacity
AFULL_LVL, 2**ADDR_W-4, count at or above which almost_full asserts

Ports:
CLK100MHZ  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state on the next rising edge
flush  in  1  synchronous queue clear, same effect as reset on pointers/flags
data_in  in  DATA_W  word to enqueue
wr_en  in  1  enqueue request
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_LVL
empty  out  1  count == 0
overflow  out  1  sticky: a write was attempted while full
count  out  ADDR_W+1  words held, including the one in the output register
data_out  out  DATA_W  head word, meaningful when tx_valid=1
tx_valid  out  1  head word present at data_out
tx_ack  in  1  launcher consumed head word (pop)

Behaviour:
- Reset and flush:
  - Reset values: full=0, almost_full=0, empty=1, overflow=0, count=0, data_out=0, tx_valid=0, wr_ptr=0, rd_ptr=0, read FSM=IDLE.
  - Storage contents are not cleared.
  - flush has identical effect (RAM untouched). Reset/flush win over wr_en/tx_ack in the same cycle.
  - Reset mid-operation aborts any in-flight read; a word pending in the output register is discarded.
- Write side:
  - Accepted when wr_en=1 and full=0, sampled at the rising edge.
  - Accepted write: mem[wr_ptr]<=data_in, wr_ptr increments modulo DEPTH.
  - wr_en=1 with full=1: word dropped, pointers unchanged, overflow<=1.
  - Full is the registered value at the edge. A same-cycle tx_ack does not allow a write while full.
- Storage read latency: 1 cycle, registered.
- Read FSM:
  - IDLE: if RAM holds an unread word, issue read of mem[rd_ptr], rd_ptr++, go LOAD.
  - LOAD: data_out<=read data, tx_valid<=1, go VALID.
  - VALID: hold data_out/tx_valid stable until tx_ack=1.
    - On ack, if another unread word exists, issue next read (go LOAD), else go IDLE.
    - On ack, tx_valid drops for exactly 1 cycle between words.
- Handshake rules:
  - tx_ack while tx_valid=0 is ignored (no underflow, count unchanged).
- Latency: a write at edge N into an empty queue gives tx_valid=1 after edge N+2.
- Count update per edge:
  - +1 on accepted write, −1 on tx_ack with tx_valid=1.
  - Both in the same cycle: unchanged.
  - Flags are derived from the next count value and registered, so they agree with count every cycle.
- Wrap-around: pointers wrap DEPTH-1→0 with no data corruption. An empty/full distinction via count means no pointer-equality ambiguity.
- Sustained throughput: writes up to 1 word/cycle; reads 1 word per 2 cycles minimum. UART frames are far slower.

Decomposition:
- Shared package (uart_pkg): read FSM state encoding (IDLE, LOAD, VALID), DATA_W default.
- Sub-module launch_fifo_mem: simple dual-port RAM, DEPTH×DATA_W, one write port, one registered read port, no reset on the array.
- The top level holds pointers, count, flags, and the FSM.

Test Plan:
- Reset then write 0xA5 at edge N -> tx_valid=1, data_out=0xA5 after edge N+2; count=1, empty=0; tx_ack -> count=0, empty=1, tx_valid=0.
- ADDR_W=3: write 8 words 0x10..0x17 -> full=1, count=8, almost_full=1 from count=4; 9th write 0xFF -> dropped, overflow=1; ack 8 times -> outputs 0x10..0x17 in order, 0xFF never seen.
- ADDR_W=3: 20 write/ack pairs with incrementing data -> pointers wrap twice, output sequence exact, count never exceeds 8.
- Full queue with wr_en=1 and tx_ack=1 in the same cycle -> write rejected, overflow=1, count=7. Half-full queue with both in the same cycle -> count unchanged.
- 5 words queued, tx_valid=1, assert flush (with wr_en=1 same cycle) -> next edge count=0, empty=1, tx_valid=0, overflow=0; a subsequent write of 0x3C emerges as the first word.
- tx_ack pulsed while empty -> count stays 0, no state change. Reset asserted in LOAD state -> tx_valid stays 0 and all outputs at reset values.
